// File: rtl/micro_cond_gen_pkg.sv
// micro_cond_gen_pkg: shared channel states, default debounce sizing and condition bit indices
package micro_cond_gen_pkg;
  typedef enum logic {ST_STABLE = 1'b0, ST_CHECK = 1'b1} deb_state_e;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int CNT_W_DEF = 3;
  localparam int X1_IDX = 0;
  localparam int X2_IDX = 1;
  localparam int X3_IDX = 2;
endpackage

// File: rtl/micro_debounce.sv
// micro_debounce: one condition channel, two-flop synchroniser followed by a debounce FSM and counter
module micro_debounce import micro_cond_gen_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_raw,
  output logic o_level,
  output logic o_chg,
  output logic o_busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
  logic r_s1, r_s2, r_level;
  logic [CNT_W-1:0] r_cnt;
  deb_state_e r_state;
  logic w_diff, w_done;
  assign w_diff = r_s2 != r_level;
  assign w_done = i_en && r_state == ST_CHECK && w_diff && r_cnt == LAST;
  // synchroniser keeps running while the channel is frozen
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
    end
  end
  // accept a new level only after it has held DEB_CYCLES enabled cycles; any return to the old level aborts
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_STABLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (i_en) begin
      if (r_state == ST_STABLE) begin
        r_state <= w_diff ? ST_CHECK : ST_STABLE;
        r_cnt   <= w_diff ? CNT_W'(1) : '0;
      end else if (!w_diff || w_done) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_level <= w_done ? r_s2 : r_level;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end
  assign o_level = r_level;
  assign o_chg   = w_done;
  assign o_busy  = r_state == ST_CHECK;
endmodule

// File: rtl/micro_cond_gen.sv
// micro_cond_gen: synchronises and debounces the three automaton condition inputs x1..x3
module micro_cond_gen import micro_cond_gen_pkg::*; #(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [2:0] i_raw,
  output logic       o_x1,
  output logic       o_x2,
  output logic       o_x3,
  output logic       o_chg,
  output logic       o_stable
);
  logic [2:0] w_level, w_chg, w_busy;
  logic r_chg;
  if (DEB_CYCLES < 2 || (2 ** CNT_W) <= DEB_CYCLES) begin : g_bad_cfg
    $error("micro_cond_gen: need DEB_CYCLES >= 2 and 2**CNT_W > DEB_CYCLES");
  end
  for (genvar c = 0; c < 3; c++) begin : g_ch
    micro_debounce #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (i_en),
      .i_raw  (i_raw[c]),
      .o_level(w_level[c]),
      .o_chg  (w_chg[c]),
      .o_busy (w_busy[c])
    );
  end
  // channels updating on the same edge merge into one pulse, aligned with the o_x* update
  always_ff @(posedge i_clk) begin
    r_chg <= i_rst ? 1'b0 : |w_chg;
  end
  assign o_x1     = w_level[X1_IDX];
  assign o_x2     = w_level[X2_IDX];
  assign o_x3     = w_level[X3_IDX];
  assign o_chg    = r_chg;
  assign o_stable = ~|w_busy;
endmodule
